// File: rtl/mac_operand_sequencer.sv
// Operand sequencer for an external multiply-accumulate unit.
// Holds an activation bank (x) and a weight bank (y). On start it clears the
// MAC, streams TAPS operand pairs into it, then captures the accumulator.

module mac_operand_sequencer #(
  parameter  int WIDTH = 16,
  parameter  int TAPS  = 9,
  localparam int AW    = (TAPS > 1) ? $clog2(TAPS) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic             wr_sel,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             mac_clear,
  output logic [WIDTH-1:0] mac_x,
  output logic [WIDTH-1:0] mac_y,
  input  logic [WIDTH-1:0] mac_in
);

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    STREAM,
    CAPTURE
  } state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(TAPS - 1);
  localparam logic [AW:0]   TAPS_EXT = (AW + 1)'(TAPS);

  state_t           state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] xbank_q [TAPS];
  logic [WIDTH-1:0] ybank_q [TAPS];
  logic [WIDTH-1:0] result_q;
  logic             done_q;
  logic             bankWrite;

  // Banks only accept writes while idle, so an operation sees a frozen snapshot.
  assign bankWrite = wr_en && (state_q == IDLE) && ({1'b0, wr_addr} < TAPS_EXT);

  // Next-state and tap index sequencing.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        idx_d = '0;
        if (start) state_d = CLEAR;
      end
      CLEAR: begin
        idx_d   = '0;
        state_d = STREAM;
      end
      STREAM: begin
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = CAPTURE;
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end
      CAPTURE: begin
        idx_d   = '0;
        state_d = IDLE;
      end
      default: begin
        idx_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State and tap index registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Operand banks: cleared on reset, written from the host port when idle.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < TAPS; i++) begin
        xbank_q[i] <= '0;
        ybank_q[i] <= '0;
      end
    end else if (bankWrite) begin
      if (wr_sel) ybank_q[wr_addr] <= wr_data;
      else        xbank_q[wr_addr] <= wr_data;
    end
  end

  // Capture the accumulator at the end of CAPTURE and flag it the next cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= (state_q == CAPTURE);
      if (state_q == CAPTURE) result_q <= mac_in;
    end
  end

  // Operands are zero outside the stream so the MAC holds its value.
  always_comb begin
    mac_x = '0;
    mac_y = '0;
    if (state_q == STREAM) begin
      mac_x = xbank_q[idx_q];
      mac_y = ybank_q[idx_q];
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign result    = result_q;
  assign mac_clear = reset || (state_q == CLEAR);

endmodule

// File: doc/mac_operand_sequencer.md
MAC_OPERAND_SEQUENCER -- requirements
Module: mac_operand_sequencer

Interface
REQ-001 Parameters SHALL be WIDTH (default 16, operand/accumulator width) and TAPS (default 9, pairs per dot product, 3x3 kernel); AW = max(1, clog2(TAPS)).
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 wr_en  input  1  write strobe into operand banks.
REQ-005 wr_sel  input  1  bank select: 0 = x bank (activations), 1 = y bank (weights).
REQ-006 wr_addr  input  AW  bank entry index.
REQ-007 wr_data  input  WIDTH  value written.
REQ-008 start  input  1  request one dot product.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 done  output  1  one-cycle pulse: result updated.
REQ-011 result  output  WIDTH  last captured dot product, held until next done.
REQ-012 mac_clear  output  1  drives the downstream MAC reset input.
REQ-013 mac_x, mac_y  output  WIDTH each  operands to the downstream MAC.
REQ-014 mac_in  input  WIDTH  downstream MAC accumulator value.

Function
REQ-015 The block SHALL hold two TAPS-entry WIDTH-bit register banks (x, y).
REQ-016 In IDLE, wr_en with wr_addr < TAPS SHALL write wr_data to the selected bank entry at the clock edge; wr_addr >= TAPS SHALL be ignored.
REQ-017 wr_en while busy SHALL be ignored; banks stay frozen for the whole operation.
REQ-018 FSM states SHALL be IDLE, CLEAR, STREAM, CAPTURE.
REQ-019 IDLE -> CLEAR when start = 1; start while busy SHALL be ignored (not queued).
REQ-020 CLEAR lasts exactly 1 cycle with mac_clear = 1, then -> STREAM with tap index = 0.
REQ-021 STREAM lasts exactly TAPS cycles; in the cycle with index i, mac_x = xbank[i], mac_y = ybank[i]; index increments each cycle; after index TAPS-1 -> CAPTURE.
REQ-022 Outside STREAM, mac_x and mac_y SHALL be 0, so the MAC holds its value.
REQ-023 mac_clear SHALL be high when reset = 1 or state = CLEAR, and low otherwise.
REQ-024 CAPTURE lasts 1 cycle: result <= mac_in at its end, done = 1 in the following cycle, state -> IDLE.
REQ-025 Latency: if start is sampled in cycle 0, done SHALL be high in cycle TAPS+3 and busy high in cycles 1..TAPS+2; done and busy are never both high.
REQ-026 start asserted in the same cycle as done (IDLE) SHALL begin a new operation; back-to-back throughput is one result per TAPS+3 cycles.
REQ-027 Write and start in the same IDLE cycle: the write SHALL take effect and the new value SHALL be used by that operation.
REQ-028 Arithmetic is performed by the MAC, modulo 2^WIDTH; result is mac_in bit-exact, with no saturation or sign handling.

Reset
REQ-029 On reset: state = IDLE, index = 0, busy = 0, done = 0, result = 0, both banks all-zero, mac_x = mac_y = 0, mac_clear = 1.
REQ-030 Reset during any non-IDLE state SHALL abort the operation with no done pulse; result keeps its reset value of 0.

Verification (TAPS = 4, WIDTH = 16, sequencer wired to the MAC)
REQ-031 Basic: write x = {1,2,3,4}, y = {5,6,7,8}, pulse start in cycle 0 -> mac_clear high in cycle 1, pairs (1,5)..(4,8) in cycles 2-5, done in cycle 7, result = 70.
REQ-032 Wrap: all x = y = 0x0100 -> result = 0x0000; x = {0xFFFF,1,0,0}, y = {1,1,0,0} -> result = 0x0000.
REQ-033 Protocol: start and wr_en (x[0] := 9) in cycles 2-4 of an operation -> no restart, bank unchanged, result = 70; next run still yields 70.
REQ-034 Back-to-back: start held high for 16 cycles -> done pulses in cycles 7 and 14, both with result = 70; mac_clear precedes each stream.
REQ-035 Reset mid-stream: reset in cycle 4 -> busy = 0, mac_clear = 1, no done, result = 0, banks = 0; a subsequent run on zero banks gives done with result 0.
REQ-036 Same-cycle write and start: write y[3] := 10 together with start -> result = 5+12+21+40 = 78.
